// File: rtl/dino_pkg.sv
// Shared types and default parameters for the dino game-flow controller.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int SCORE_W_DEF   = 16;
  localparam int TICK_DIV_DEF  = 416667;
  localparam int OVER_HOLD_DEF = 30;

endpackage

// File: rtl/dino_tick_gen.sv
// Free-running frame-tick divider: one-cycle frame_tick every TICK_DIV clocks.
module dino_tick_gen
  import dino_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  output logic frame_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign frame_tick = (cnt == CNT_MAX);

endmodule

// File: rtl/dino_game_ctrl.sv
// Game-flow controller: button sync/edge detect, IDLE/RUN/OVER sequencing and
// score-counter pulses. Define DINO_HISCORE_EN to build the session high score.
module dino_game_ctrl
  import dino_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int OVER_HOLD = OVER_HOLD_DEF,
  parameter int SCORE_W   = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_jump,
  input  logic               collision,
  input  logic [SCORE_W-1:0] score,
  output logic               game_start,
  output logic               game_over,
  output logic               game_tick,
  output logic               frame_tick,
  output logic               running,
  output logic [1:0]         state
`ifdef DINO_HISCORE_EN
  ,
  output logic [SCORE_W-1:0] hiscore
`endif
);

  localparam int HOLD_W = $clog2(OVER_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OVER_HOLD);

  state_t            state_r, state_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              start_nxt, over_nxt;
  logic              btn_p0, btn_p1, btn_p2;
  logic              press;

  dino_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick)
  );

  // Button: two-flop synchroniser (p0, p1) then previous-value flop (p2)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_p0 <= 1'b0;
      btn_p1 <= 1'b0;
      btn_p2 <= 1'b0;
    end else begin
      btn_p0 <= btn_jump;
      btn_p1 <= btn_p0;
      btn_p2 <= btn_p1;
    end
  end

  assign press = btn_p1 & ~btn_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      hold_cnt   <= '0;
      game_start <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      hold_cnt   <= hold_nxt;
      game_start <= start_nxt;
      game_over  <= over_nxt;
    end
  end

  always_comb begin
    state_nxt = state_r;
    hold_nxt  = hold_cnt;
    start_nxt = 1'b0;
    over_nxt  = 1'b0;
    case (state_r)
      IDLE: begin
        if (press) begin
          state_nxt = RUN;
          start_nxt = 1'b1;
        end
      end
      RUN: begin
        // Collision has priority; a press in RUN is never acted on
        if (collision) begin
          state_nxt = OVER;
          over_nxt  = 1'b1;
          hold_nxt  = '0;
        end
      end
      OVER: begin
        if (hold_cnt == HOLD_MAX) begin
          state_nxt = IDLE;
        end else if (frame_tick) begin
          hold_nxt = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign running   = (state_r == RUN);
  assign game_tick = frame_tick & running;
  assign state     = state_r;

`ifdef DINO_HISCORE_EN
  logic hs_chk;

  // Compare one cycle after game_over so the counter's final score has settled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_chk  <= 1'b0;
      hiscore <= '0;
    end else begin
      hs_chk <= game_over;
      if (hs_chk && (score > hiscore)) begin
        hiscore <= score;
      end
    end
  end
`else
  logic unused_score;
  assign unused_score = ^score;
`endif

endmodule

// File: tb/tb_dino_game_ctrl.sv
// Directed bench for dino_game_ctrl with TICK_DIV=4, OVER_HOLD=2.
module tb_dino_game_ctrl;

  localparam int TDIV = 4;
  localparam int HOLD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_jump;
  logic        collision;
  logic [15:0] score;
  logic        game_start, game_over, game_tick, frame_tick, running;
  logic [1:0]  state;
`ifdef DINO_HISCORE_EN
  logic [15:0] hiscore;
`endif

  int checks = 0;
  int errors = 0;
  int exp_cnt;
  int fticks;
  int over_len;

  always #5 clk = ~clk;

  // Reference frame counter: frame_tick expected when it sits at TDIV-1
  always @(posedge clk or posedge rst) begin
    if (rst) exp_cnt <= 0;
    else     exp_cnt <= (exp_cnt == TDIV - 1) ? 0 : exp_cnt + 1;
  end

  dino_game_ctrl #(
    .TICK_DIV  (TDIV),
    .OVER_HOLD (HOLD),
    .SCORE_W   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_jump   (btn_jump),
    .collision  (collision),
    .score      (score),
    .game_start (game_start),
    .game_over  (game_over),
    .game_tick  (game_tick),
    .frame_tick (frame_tick),
    .running    (running),
    .state      (state)
`ifdef DINO_HISCORE_EN
    ,
    .hiscore    (hiscore)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40 && state != 2'd0; i++) @(negedge clk);
    chk(tag, {30'd0, state}, 32'd0);
  endtask

`ifdef DINO_HISCORE_EN
  task automatic play(input logic [15:0] v);
    btn_jump = 1'b1;
    cyc(3);
    chk("hs_run", {30'd0, state}, 32'd1);
    btn_jump = 1'b0;
    score = v;
    cyc(2);
    collision = 1'b1;
    cyc(1);
    collision = 1'b0;
    wait_idle("hs_back_idle");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; btn_jump = 1'b0; collision = 1'b0; score = 16'h0000;
    cyc(2);
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_pulses", {28'd0, game_start, game_over, game_tick, running}, 32'd0);
    chk("rst_frame", {31'd0, frame_tick}, 32'd0);
`ifdef DINO_HISCORE_EN
    chk("rst_hiscore", {16'd0, hiscore}, 32'd0);
`endif
    rst = 1'b0;

    // Idle: divider runs, nothing else moves
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("idle_frame", {31'd0, frame_tick}, {31'd0, (exp_cnt == TDIV - 1)});
      chk("idle_pulses", {28'd0, game_start, game_over, game_tick, running}, 32'd0);
      chk("idle_state", {30'd0, state}, 32'd0);
    end

    // Collision in IDLE is ignored
    collision = 1'b1;
    cyc(1);
    collision = 1'b0;
    cyc(2);
    chk("idle_coll_state", {30'd0, state}, 32'd0);
    chk("idle_coll_over", {31'd0, game_over}, 32'd0);

    // Press: game_start on the third edge after the pin rises
    btn_jump = 1'b1;
    cyc(1);
    chk("start_lat1", {31'd0, game_start}, 32'd0);
    cyc(1);
    chk("start_lat2", {31'd0, game_start}, 32'd0);
    chk("start_lat2_state", {30'd0, state}, 32'd0);
    cyc(1);
    chk("start_pulse", {31'd0, game_start}, 32'd1);
    chk("start_state", {30'd0, state}, 32'd1);
    chk("start_running", {31'd0, running}, 32'd1);
    cyc(1);
    chk("start_once", {31'd0, game_start}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("run_tick", {31'd0, game_tick}, {31'd0, (exp_cnt == TDIV - 1)});
      chk("run_state", {30'd0, state}, 32'd1);
    end

    // Second press while running does nothing
    btn_jump = 1'b0;
    cyc(3);
    btn_jump = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("repress_start", {31'd0, game_start}, 32'd0);
      chk("repress_state", {30'd0, state}, 32'd1);
    end
    btn_jump = 1'b0;

    // Collision coinciding with a frame tick still issues that game_tick
    for (int i = 0; i < 8 && exp_cnt != TDIV - 1; i++) cyc(1);
    collision = 1'b1;
    #1;
    chk("coll_tick", {31'd0, game_tick}, 32'd1);
    cyc(1);
    collision = 1'b0;
    chk("over_pulse", {31'd0, game_over}, 32'd1);
    chk("over_state", {30'd0, state}, 32'd2);
    chk("over_notick", {31'd0, game_tick}, 32'd0);
    chk("over_running", {31'd0, running}, 32'd0);
    cyc(1);
    chk("over_once", {31'd0, game_over}, 32'd0);

    // OVER lasts two frame ticks plus one cycle (9 cycles from this entry phase)
    fticks = 0;
    over_len = 0;
    for (int i = 0; i < 40 && state == 2'd2; i++) begin
      if (frame_tick) fticks++;
      chk("over_gt", {31'd0, game_tick}, 32'd0);
      over_len++;
      cyc(1);
    end
    chk("over_ticks", fticks, 32'd2);
    chk("over_len", over_len, 32'd8);
    chk("over_to_idle", {30'd0, state}, 32'd0);

    // Collision and press together in RUN: collision wins
    btn_jump = 1'b1;
    cyc(3);
    chk("cp_run", {30'd0, state}, 32'd1);
    btn_jump = 1'b0;
    cyc(3);
    btn_jump = 1'b1;
    cyc(2);
    collision = 1'b1;
    cyc(1);
    collision = 1'b0;
    chk("cp_state", {30'd0, state}, 32'd2);
    chk("cp_start", {31'd0, game_start}, 32'd0);
    chk("cp_over", {31'd0, game_over}, 32'd1);
    btn_jump = 1'b0;
    wait_idle("cp_idle");

    // Asynchronous reset during the game_start cycle
    btn_jump = 1'b1;
    cyc(3);
    chk("ar_start", {31'd0, game_start}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_state", {30'd0, state}, 32'd0);
    chk("ar_pulses", {28'd0, game_start, game_over, game_tick, running}, 32'd0);
    chk("ar_frame", {31'd0, frame_tick}, 32'd0);
    btn_jump = 1'b0;
    cyc(1);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("ar_idle_state", {30'd0, state}, 32'd0);
      chk("ar_frame_rs", {31'd0, frame_tick}, {31'd0, (exp_cnt == TDIV - 1)});
    end
    btn_jump = 1'b1;
    cyc(3);
    chk("ar_restart", {30'd0, state}, 32'd1);
    btn_jump = 1'b0;
    collision = 1'b1;
    cyc(1);
    collision = 1'b0;
    wait_idle("ar_end_idle");

`ifdef DINO_HISCORE_EN
    play(16'h0123);
    chk("hs_first", {16'd0, hiscore}, 32'h0123);
    play(16'h0050);
    chk("hs_lower", {16'd0, hiscore}, 32'h0123);
    play(16'hFFFF);
    chk("hs_max", {16'd0, hiscore}, 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
